// File: rtl/xm_mem_responder.sv
// Memory-side responder: accepts word/byte read/write requests from the CPU
// controller, stalls it through a configurable wait period and then performs
// the access on an internal RAM.
module xm_mem_responder #(
  parameter int unsigned WORD        = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] adr_i,
  input  logic [WORD-1:0] data_i,
  output logic [WORD-1:0] data_o,
  output logic            memBusy_o,
  output logic            memWr_o,
  output logic            memErr_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW = WORD - 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WS_LAST = CW'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WORD-1:0] adr_q, adr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic            byte_q, byte_d;
  logic [WORD-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic [WORD-1:0] ram_q [DEPTH];
  logic [IW-1:0]   word_idx;
  logic [AW-1:0]   ram_idx;
  logic            in_range;
  logic [WORD-1:0] cur_word;
  logic [7:0]      lane;
  logic [WORD-1:0] rd_val;
  logic [WORD-1:0] ram_wdata;
  logic            ram_we;

  // Address decode and read/merge data for the latched request
  always_comb begin
    word_idx  = adr_q[WORD-1:1];
    ram_idx   = word_idx[AW-1:0];
    in_range  = (32'(word_idx) < DEPTH);
    cur_word  = ram_q[ram_idx];
    lane      = adr_q[0] ? cur_word[15:8] : cur_word[7:0];
    rd_val    = byte_q ? WORD'(lane) : cur_word;
    ram_wdata = wdata_q;
    if (byte_q) begin
      ram_wdata = cur_word;
      if (adr_q[0]) ram_wdata[15:8] = wdata_q[7:0];
      else          ram_wdata[7:0]  = wdata_q[7:0];
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> ACCESS -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    byte_d  = byte_q;
    data_d  = data_q;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memEn_i) begin
          adr_d   = adr_i;
          wdata_d = data_i;
          rw_d    = memRW_i;
          byte_d  = byteOp_i;
          cnt_d   = '0;
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == WS_LAST) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        err_d   = ~in_range;
        if (rw_q) ram_we = in_range;
        else      data_d = in_range ? rd_val : '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      byte_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // RAM array write port (contents survive reset)
  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[ram_idx] <= ram_wdata;
  end

  // Busy/write flags include the request cycle so the controller stalls at once
  always_comb begin
    data_o    = data_q;
    memErr_o  = err_q;
    memBusy_o = arst_i & ((state_q != S_IDLE) | memEn_i);
    memWr_o   = arst_i & ((state_q == S_IDLE) ? (memEn_i & memRW_i) : rw_q);
  end

endmodule

// File: tb/tb_xm_mem_responder.sv
// Directed bench for xm_mem_responder: one instance with one wait state,
// one with none, driven and checked cycle by cycle.
module tb_xm_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        en   [2];
  logic        rw   [2];
  logic        bo   [2];
  logic [15:0] adr  [2];
  logic [15:0] din  [2];
  logic [15:0] dout [2];
  logic        busy [2];
  logic        wr   [2];
  logic        err  [2];

  int n_tests = 0;
  int n_fail  = 0;

  xm_mem_responder #(.WORD(16), .DEPTH(256), .WAIT_STATES(1)) u_dut_ws1 (
    .clk_i(clk), .arst_i(rst_n), .memEn_i(en[0]), .memRW_i(rw[0]),
    .byteOp_i(bo[0]), .adr_i(adr[0]), .data_i(din[0]), .data_o(dout[0]),
    .memBusy_o(busy[0]), .memWr_o(wr[0]), .memErr_o(err[0])
  );

  xm_mem_responder #(.WORD(16), .DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
    .clk_i(clk), .arst_i(rst_n), .memEn_i(en[1]), .memRW_i(rw[1]),
    .byteOp_i(bo[1]), .adr_i(adr[1]), .data_i(din[1]), .data_o(dout[1]),
    .memBusy_o(busy[1]), .memWr_o(wr[1]), .memErr_o(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete access on instance d; starts just after a rising edge and
  // returns just after the edge that follows the completion cycle.
  task automatic acc(input int d, input logic w, input logic b,
                     input logic [15:0] a, input logic [15:0] wd,
                     output int nbusy, output int nwr,
                     output logic [15:0] rd, output logic er);
    logic done;
    nbusy = 0; nwr = 0; rd = '0; er = 1'b0; done = 1'b0;
    en[d] = 1'b1; rw[d] = w; bo[d] = b; adr[d] = a; din[d] = wd;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!busy[d]) begin
        done = 1'b1;
        rd   = dout[d];
        er   = err[d];
      end else begin
        nbusy++;
        if (wr[d]) nwr++;
        @(posedge clk); #1;
        en[d] = 1'b0; rw[d] = 1'b0; bo[d] = 1'b0;
      end
    end
    if (!done) check("access_timeout", 32'(nbusy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          nb;
    int          nw;
    logic [15:0] rd;
    logic        er;
    logic [15:0] b2b_adr [3];
    logic [15:0] b2b_dat [3];

    b2b_adr[0] = 16'h0004; b2b_adr[1] = 16'h0006; b2b_adr[2] = 16'h0008;
    b2b_dat[0] = 16'h0101; b2b_dat[1] = 16'h0202; b2b_dat[2] = 16'h0303;

    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; rw[d] = 1'b0; bo[d] = 1'b0; adr[d] = '0; din[d] = '0;
    end

    // Reset: outputs low even with a write request pending at the inputs
    rst_n = 1'b0;
    en[0] = 1'b1; rw[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_wr",   32'(wr[0]),   32'd0);
    check("rst_data", 32'(dout[0]), 32'd0);
    check("rst_err",  32'(err[0]),  32'd0);
    en[0] = 1'b0; rw[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word write then word read, one wait state
    acc(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, nb, nw, rd, er);
    check("t1_wr_busy", 32'(nb), 32'd3);
    check("t1_wr_memwr", 32'(nw), 32'd3);
    check("t1_wr_data_held", 32'(rd), 32'h0);
    check("t1_wr_err", 32'(er), 32'd0);
    acc(0, 1'b0, 1'b0, 16'h0010, 16'h0000, nb, nw, rd, er);
    check("t1_rd_busy", 32'(nb), 32'd3);
    check("t1_rd_memwr", 32'(nw), 32'd0);
    check("t1_rd_data", 32'(rd), 32'hBEEF);

    // Byte write to upper lane, then word/byte reads
    acc(0, 1'b1, 1'b1, 16'h0011, 16'h0055, nb, nw, rd, er);
    check("t2_bw_busy", 32'(nb), 32'd3);
    acc(0, 1'b0, 1'b0, 16'h0010, 16'h0000, nb, nw, rd, er);
    check("t2_word_rd", 32'(rd), 32'h55EF);
    acc(0, 1'b0, 1'b1, 16'h0010, 16'h0000, nb, nw, rd, er);
    check("t2_byte_rd_lo", 32'(rd), 32'h00EF);
    acc(0, 1'b0, 1'b1, 16'h0011, 16'h0000, nb, nw, rd, er);
    check("t2_byte_rd_hi", 32'(rd), 32'h0055);
    acc(0, 1'b0, 1'b0, 16'h0011, 16'h0000, nb, nw, rd, er);
    check("t2_word_rd_unaligned", 32'(rd), 32'h55EF);

    // Out-of-range read and write (index 0x101 aliases word 1 in low bits)
    acc(0, 1'b1, 1'b0, 16'h0002, 16'hA5A5, nb, nw, rd, er);
    check("t3_seed_err", 32'(er), 32'd0);
    acc(0, 1'b0, 1'b0, 16'h0203, 16'h0000, nb, nw, rd, er);
    check("t3_oor_rd_data", 32'(rd), 32'h0);
    check("t3_oor_rd_err", 32'(er), 32'd1);
    check("t3_oor_rd_busy", 32'(nb), 32'd3);
    @(negedge clk);
    check("t3_err_one_cycle", 32'(err[0]), 32'd0);
    @(posedge clk); #1;
    acc(0, 1'b1, 1'b0, 16'h0202, 16'h1234, nb, nw, rd, er);
    check("t3_oor_wr_err", 32'(er), 32'd1);
    acc(0, 1'b0, 1'b0, 16'h0002, 16'h0000, nb, nw, rd, er);
    check("t3_ram_unchanged", 32'(rd), 32'hA5A5);
    check("t3_inrange_err", 32'(er), 32'd0);

    // Zero wait states: writes take two busy cycles
    for (int i = 0; i < 3; i++) begin
      acc(1, 1'b1, 1'b0, b2b_adr[i], b2b_dat[i], nb, nw, rd, er);
      check("t4_wr_busy", 32'(nb), 32'd2);
    end

    // Back-to-back reads with memEn_i held high
    en[1] = 1'b1; rw[1] = 1'b0; bo[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adr[1] = b2b_adr[i];
      @(negedge clk);
      if (i > 0) check("t4_b2b_data", 32'(dout[1]), 32'(b2b_dat[i-1]));
      check("t4_b2b_busy_req", 32'(busy[1]), 32'd1);
      @(posedge clk); #1;
      adr[1] = 16'h00F0;
      @(negedge clk);
      check("t4_b2b_busy_acc", 32'(busy[1]), 32'd1);
      @(posedge clk); #1;
    end
    en[1] = 1'b0;
    @(negedge clk);
    check("t4_b2b_last_data", 32'(dout[1]), 32'h0303);
    check("t4_b2b_idle", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;

    // Request pulsed during WAIT is ignored
    en[0] = 1'b1; rw[0] = 1'b0; bo[0] = 1'b0; adr[0] = 16'h0010;
    @(posedge clk); #1;
    en[0] = 1'b1; rw[0] = 1'b1; adr[0] = 16'h0002; din[0] = 16'hDEAD;
    @(negedge clk);
    check("t6_wait_busy", 32'(busy[0]), 32'd1);
    check("t6_wait_memwr", 32'(wr[0]), 32'd0);
    @(posedge clk); #1;
    en[0] = 1'b0; rw[0] = 1'b0;
    @(negedge clk);
    check("t6_access_busy", 32'(busy[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_done_busy", 32'(busy[0]), 32'd0);
    check("t6_done_data", 32'(dout[0]), 32'h55EF);
    @(posedge clk); #1;
    acc(0, 1'b0, 1'b0, 16'h0002, 16'h0000, nb, nw, rd, er);
    check("t6_no_stray_write", 32'(rd), 32'hA5A5);

    // Reset during WAIT aborts a write
    acc(0, 1'b1, 1'b0, 16'h0020, 16'h1111, nb, nw, rd, er);
    en[0] = 1'b1; rw[0] = 1'b1; adr[0] = 16'h0020; din[0] = 16'h2222;
    @(posedge clk); #1;
    en[0] = 1'b0; rw[0] = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", 32'(busy[0]), 32'd0);
    check("t5_rst_wr",   32'(wr[0]),   32'd0);
    check("t5_rst_data", 32'(dout[0]), 32'd0);
    check("t5_rst_err",  32'(err[0]),  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc(0, 1'b0, 1'b0, 16'h0020, 16'h0000, nb, nw, rd, er);
    check("t5_old_value", 32'(rd), 32'h1111);
    check("t5_busy_after_rst", 32'(nb), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
